// File: rtl/load_store_queue.sv
// In-order load/store queue: dispatch at tail, CDB wake-up, head issue to memory one cycle after eligibility.
// Issue stalls while a presented request is not accepted; dispatch is dropped when all DEPTH slots are busy.
module load_store_queue #(
  parameter int          DEPTH       = 16,
  parameter int          TAG_W       = 5,
  parameter int          FULL_MARGIN = 2,
  parameter logic [31:0] IO_ADDR     = 32'h0003_0000
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,

  input  logic                   disp_valid,
  input  logic [5:0]             disp_op,
  input  logic [TAG_W-1:0]       disp_q1,
  input  logic [TAG_W-1:0]       disp_q2,
  input  logic [31:0]            disp_v1,
  input  logic [31:0]            disp_v2,
  input  logic [31:0]            disp_imm,
  input  logic [TAG_W-1:0]       disp_tag,

  input  logic                   cdb0_valid,
  input  logic [TAG_W-1:0]       cdb0_tag,
  input  logic [31:0]            cdb0_data,
  input  logic                   cdb1_valid,
  input  logic [TAG_W-1:0]       cdb1_tag,
  input  logic [31:0]            cdb1_data,

  input  logic                   commit_valid,
  input  logic [TAG_W-1:0]       commit_tag,
  input  logic [TAG_W-1:0]       rob_io_head_tag,
  input  logic                   rollback,

  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic [5:0]             mem_req_op,
  output logic [31:0]            mem_req_addr,
  output logic [31:0]            mem_req_wdata,
  output logic [TAG_W-1:0]       mem_req_tag,

  output logic [TAG_W-1:0]       io_tag,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full_warn,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] WARN_TH_C = CW'(DEPTH - FULL_MARGIN);

  // Opcode ordering: all loads encode at or below LHU, all stores at or above SB.
  localparam logic [5:0] OP_LHU = 6'd4;
  localparam logic [5:0] OP_SB  = 6'd5;

  typedef struct packed {
    logic             busy;
    logic             committed;
    logic [5:0]       op;
    logic [TAG_W-1:0] q1;
    logic [TAG_W-1:0] q2;
    logic [31:0]      v1;
    logic [31:0]      v2;
    logic [31:0]      imm;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t          ent [DEPTH];
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;

  entry_t          head_e;
  logic [31:0]     head_addr;
  logic            head_is_load;
  logic            head_is_store;
  logic            head_rdy;
  logic            can_issue;
  logic            do_insert;
  entry_t          ins;
  logic [CW-1:0]   kept;

  assign head_e        = ent[head];
  assign head_addr     = head_e.v1 + head_e.imm;
  assign head_is_load  = (head_e.op <= OP_LHU);
  assign head_is_store = (head_e.op >= OP_SB);

  // Tag 0 means "no I/O load at ROB head", so it never releases an I/O load.
  assign head_rdy = head_e.busy && (head_e.q1 == '0) && (head_e.q2 == '0) &&
                    ((head_is_load && ((head_addr != IO_ADDR) ||
                                       (rob_io_head_tag != '0 && rob_io_head_tag == head_e.tag))) ||
                     (head_is_store && head_e.committed));

  assign can_issue = head_rdy && (!mem_req_valid || mem_req_ready);
  assign do_insert = disp_valid && (count < DEPTH_C);

  assign io_tag    = (head_e.busy && head_e.q1 == '0 && head_addr == IO_ADDR) ? head_e.tag : '0;
  assign empty     = (count == '0);
  assign full_warn = (count >= WARN_TH_C);

  always_comb begin
    ins           = '0;
    ins.busy      = 1'b1;
    ins.committed = 1'b0;
    ins.op        = disp_op;
    ins.imm       = disp_imm;
    ins.tag       = disp_tag;
    ins.q1        = disp_q1;
    ins.v1        = disp_v1;
    ins.q2        = disp_q2;
    ins.v2        = disp_v2;
    if (disp_q1 != '0) begin
      if (cdb0_valid && cdb0_tag == disp_q1) begin
        ins.q1 = '0;
        ins.v1 = cdb0_data;
      end else if (cdb1_valid && cdb1_tag == disp_q1) begin
        ins.q1 = '0;
        ins.v1 = cdb1_data;
      end
    end
    if (disp_q2 != '0) begin
      if (cdb0_valid && cdb0_tag == disp_q2) begin
        ins.q2 = '0;
        ins.v2 = cdb0_data;
      end else if (cdb1_valid && cdb1_tag == disp_q2) begin
        ins.q2 = '0;
        ins.v2 = cdb1_data;
      end
    end
  end

  // Length of the run of committed stores starting at head; these survive a rollback.
  always_comb begin
    logic [AW-1:0] idx;
    logic          run;
    kept = '0;
    run  = 1'b1;
    idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + AW'(i);
      if (run && ent[idx].busy && ent[idx].committed && (ent[idx].op >= OP_SB))
        kept = kept + CW'(1);
      else
        run = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      mem_req_valid <= 1'b0;
      mem_req_op    <= '0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      mem_req_tag   <= '0;
    end else if (rdy_in) begin
      if (mem_req_valid && mem_req_ready) mem_req_valid <= 1'b0;

      if (rollback) begin
        for (int i = 0; i < DEPTH; i++) begin
          if ({1'b0, (AW'(i) - head)} >= kept) begin
            ent[i].busy      <= 1'b0;
            ent[i].committed <= 1'b0;
          end
        end
        tail  <= head + kept[AW-1:0];
        count <= kept;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (ent[i].busy && ent[i].q1 != '0) begin
            if (cdb0_valid && cdb0_tag == ent[i].q1) begin
              ent[i].v1 <= cdb0_data;
              ent[i].q1 <= '0;
            end else if (cdb1_valid && cdb1_tag == ent[i].q1) begin
              ent[i].v1 <= cdb1_data;
              ent[i].q1 <= '0;
            end
          end
          if (ent[i].busy && ent[i].q2 != '0) begin
            if (cdb0_valid && cdb0_tag == ent[i].q2) begin
              ent[i].v2 <= cdb0_data;
              ent[i].q2 <= '0;
            end else if (cdb1_valid && cdb1_tag == ent[i].q2) begin
              ent[i].v2 <= cdb1_data;
              ent[i].q2 <= '0;
            end
          end
          if (commit_valid && ent[i].busy && !ent[i].committed && ent[i].tag == commit_tag)
            ent[i].committed <= 1'b1;
        end

        if (do_insert) begin
          ent[tail] <= ins;
          tail      <= tail + AW'(1);
        end

        if (can_issue) begin
          mem_req_valid         <= 1'b1;
          mem_req_op            <= head_e.op;
          mem_req_addr          <= head_addr;
          mem_req_wdata         <= head_e.v2;
          mem_req_tag           <= head_e.tag;
          ent[head].busy        <= 1'b0;
          ent[head].committed   <= 1'b0;
          head                  <= head + AW'(1);
        end

        count <= count + CW'(do_insert) - CW'(can_issue);
      end
    end
  end

endmodule

// File: tb/tb_load_store_queue.sv
// Directed bench for load_store_queue (DEPTH=4): scoreboard of expected memory requests plus state checks.
module tb_load_store_queue;

  localparam logic [31:0] IO_ADDR = 32'h0003_0000;
  localparam logic [5:0]  OP_LW   = 6'd2;
  localparam logic [5:0]  OP_SW   = 6'd7;

  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  tag;
  } req_t;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic        disp_valid;
  logic [5:0]  disp_op;
  logic [4:0]  disp_q1, disp_q2, disp_tag;
  logic [31:0] disp_v1, disp_v2, disp_imm;
  logic        cdb0_valid, cdb1_valid;
  logic [4:0]  cdb0_tag, cdb1_tag;
  logic [31:0] cdb0_data, cdb1_data;
  logic        commit_valid, rollback;
  logic [4:0]  commit_tag, rob_io_head_tag;
  logic        mem_req_valid, mem_req_ready;
  logic [5:0]  mem_req_op;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [4:0]  mem_req_tag, io_tag;
  logic [2:0]  count;
  logic        full_warn, empty;

  int   checks   = 0;
  int   failures = 0;
  req_t exp_q[$];

  always #5 clk_in = ~clk_in;

  load_store_queue #(.DEPTH(4), .TAG_W(5), .FULL_MARGIN(2), .IO_ADDR(IO_ADDR)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .disp_valid(disp_valid), .disp_op(disp_op), .disp_q1(disp_q1), .disp_q2(disp_q2),
    .disp_v1(disp_v1), .disp_v2(disp_v2), .disp_imm(disp_imm), .disp_tag(disp_tag),
    .cdb0_valid(cdb0_valid), .cdb0_tag(cdb0_tag), .cdb0_data(cdb0_data),
    .cdb1_valid(cdb1_valid), .cdb1_tag(cdb1_tag), .cdb1_data(cdb1_data),
    .commit_valid(commit_valid), .commit_tag(commit_tag),
    .rob_io_head_tag(rob_io_head_tag), .rollback(rollback),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_op(mem_req_op),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_tag(mem_req_tag),
    .io_tag(io_tag), .count(count), .full_warn(full_warn), .empty(empty)
  );

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic expect_req(input logic [5:0] op, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [4:0] tag);
    req_t r;
    r = '{op, addr, wdata, tag};
    exp_q.push_back(r);
  endtask

  // One clock; a request accepted at this edge is popped from the scoreboard and compared.
  task automatic tick();
    logic fired;
    req_t r, e;
    fired = mem_req_valid && mem_req_ready && rdy_in && !rst_in;
    r = '{mem_req_op, mem_req_addr, mem_req_wdata, mem_req_tag};
    @(posedge clk_in);
    #1;
    if (fired === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL req_unexpected observed_tag=%0d addr=%h expected=none", r.tag, r.addr);
      end else begin
        e = exp_q.pop_front();
        chk("req_op", 32'(r.op), 32'(e.op));
        chk("req_addr", r.addr, e.addr);
        chk("req_wdata", r.wdata, e.wdata);
        chk("req_tag", 32'(r.tag), 32'(e.tag));
      end
    end
  endtask

  task automatic disp(input logic [5:0] op, input logic [4:0] tag, input logic [4:0] q1,
                      input logic [4:0] q2, input logic [31:0] v1, input logic [31:0] v2,
                      input logic [31:0] imm);
    disp_valid = 1'b1; disp_op = op; disp_tag = tag; disp_q1 = q1; disp_q2 = q2;
    disp_v1 = v1; disp_v2 = v2; disp_imm = imm;
    tick();
    disp_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    int n;
    n = 0;
    while ((count != 3'd0 || mem_req_valid) && n < max_cycles) begin
      tick();
      n++;
    end
    chk("drain_done", 32'(count == 3'd0 && !mem_req_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; mem_req_ready = 1'b1;
    disp_valid = 0; disp_op = 0; disp_q1 = 0; disp_q2 = 0; disp_tag = 0;
    disp_v1 = 0; disp_v2 = 0; disp_imm = 0;
    cdb0_valid = 0; cdb0_tag = 0; cdb0_data = 0; cdb1_valid = 0; cdb1_tag = 0; cdb1_data = 0;
    commit_valid = 0; commit_tag = 0; rob_io_head_tag = 0; rollback = 0;
    tick(); tick();
    rst_in = 1'b0;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full_warn", 32'(full_warn), 0);
    chk("rst_req_valid", 32'(mem_req_valid), 0);
    chk("rst_req_addr", mem_req_addr, 0);
    chk("rst_io_tag", 32'(io_tag), 0);

    // Ready load: issued one cycle after it becomes resident.
    expect_req(OP_LW, 32'h104, 32'h0, 5'd1);
    disp(OP_LW, 5'd1, 0, 0, 32'h100, 32'h0, 32'h4);
    chk("ld_count_after_disp", 32'(count), 1);
    chk("ld_empty_after_disp", 32'(empty), 0);
    tick();
    chk("ld_req_valid", 32'(mem_req_valid), 1);
    chk("ld_req_addr", mem_req_addr, 32'h104);
    chk("ld_count_after_issue", 32'(count), 0);
    tick();
    chk("ld_req_dropped", 32'(mem_req_valid), 0);
    chk("ld_empty", 32'(empty), 1);

    // Insert bypass from cdb0; a valid broadcast of tag 0 must not touch q2 == 0.
    cdb0_valid = 1; cdb0_tag = 5'd5; cdb0_data = 32'h300;
    cdb1_valid = 1; cdb1_tag = 5'd0; cdb1_data = 32'h1234_5678;
    expect_req(OP_LW, 32'h310, 32'h77, 5'd4);
    disp(OP_LW, 5'd4, 5'd5, 5'd0, 32'hBAD, 32'h77, 32'h10);
    cdb0_valid = 0; cdb1_valid = 0;
    tick();
    chk("byp_req_addr", mem_req_addr, 32'h310);
    tick();

    // Store: waits on q1 (woken by cdb1), then on commit.
    disp(OP_SW, 5'd2, 5'd3, 5'd0, 32'h0, 32'hDEAD_BEEF, 32'h8);
    cdb1_valid = 1; cdb1_tag = 5'd3; cdb1_data = 32'h2000;
    tick();
    cdb1_valid = 0;
    tick(); tick();
    chk("st_no_issue_uncommitted", 32'(mem_req_valid), 0);
    chk("st_io_tag_zero", 32'(io_tag), 0);
    expect_req(OP_SW, 32'h2008, 32'hDEAD_BEEF, 5'd2);
    commit_valid = 1; commit_tag = 5'd2;
    tick();
    commit_valid = 0;
    tick();
    chk("st_req_valid", 32'(mem_req_valid), 1);
    chk("st_req_addr", mem_req_addr, 32'h2008);
    tick();

    // Both operands woken by both CDBs in the same cycle.
    disp(OP_SW, 5'd6, 5'd8, 5'd9, 32'h0, 32'h0, 32'h20);
    cdb0_valid = 1; cdb0_tag = 5'd9; cdb0_data = 32'h55;
    cdb1_valid = 1; cdb1_tag = 5'd8; cdb1_data = 32'h1000;
    tick();
    cdb0_valid = 0; cdb1_valid = 0;
    expect_req(OP_SW, 32'h1020, 32'h55, 5'd6);
    commit_valid = 1; commit_tag = 5'd6;
    tick();
    commit_valid = 0;
    tick(); tick();
    chk("dual_wake_idle", 32'(mem_req_valid), 0);

    // I/O load held until it is the ROB's I/O head.
    rob_io_head_tag = 5'd0;
    disp(OP_LW, 5'd7, 0, 0, IO_ADDR, 32'h0, 32'h0);
    tick();
    chk("io_tag_exposed", 32'(io_tag), 7);
    chk("io_no_issue", 32'(mem_req_valid), 0);
    expect_req(OP_LW, IO_ADDR, 32'h0, 5'd7);
    rob_io_head_tag = 5'd7;
    tick();
    chk("io_req_valid", 32'(mem_req_valid), 1);
    chk("io_req_addr", mem_req_addr, IO_ADDR);
    rob_io_head_tag = 5'd0;
    tick();
    chk("io_tag_cleared", 32'(io_tag), 0);

    // Fill past capacity with uncommitted stores; the fifth is dropped.
    for (int k = 0; k < 5; k++) begin
      disp(OP_SW, 5'(10 + k), 0, 0, 32'(k) * 32'h40, 32'(k), 32'h0);
      chk("fill_count", 32'(count), (k < 4) ? 32'(k + 1) : 32'd4);
      chk("fill_full_warn", 32'(full_warn), (k >= 1) ? 32'd1 : 32'd0);
    end
    for (int k = 0; k < 4; k++) expect_req(OP_SW, 32'(k) * 32'h40, 32'(k), 5'(10 + k));
    for (int k = 0; k < 4; k++) begin
      commit_valid = 1; commit_tag = 5'(10 + k);
      tick();
    end
    commit_valid = 0;
    wait_idle(20);
    chk("fill_sb_empty", 32'(exp_q.size()), 0);

    // Refill across the pointer wrap.
    for (int k = 0; k < 3; k++) begin
      expect_req(OP_LW, 32'h800 + 32'(k) * 4, 32'h0, 5'(16 + k));
      disp(OP_LW, 5'(16 + k), 0, 0, 32'h800, 32'h0, 32'(k) * 4);
    end
    wait_idle(20);

    // Backpressure: request held, head unchanged, next entry issues on acceptance.
    expect_req(OP_LW, 32'h500, 32'h0, 5'd20);
    expect_req(OP_LW, 32'h600, 32'h0, 5'd21);
    disp(OP_LW, 5'd20, 0, 0, 32'h500, 32'h0, 32'h0);
    disp(OP_LW, 5'd21, 0, 0, 32'h600, 32'h0, 32'h0);
    mem_req_ready = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_valid", 32'(mem_req_valid), 1);
      chk("bp_addr", mem_req_addr, 32'h500);
      chk("bp_tag", 32'(mem_req_tag), 20);
      chk("bp_count", 32'(count), 1);
    end
    mem_req_ready = 1;
    tick();
    chk("bp_next_valid", 32'(mem_req_valid), 1);
    chk("bp_next_addr", mem_req_addr, 32'h600);
    tick();
    chk("bp_done_valid", 32'(mem_req_valid), 0);

    // Rollback keeps only the committed store at head; the held request survives.
    mem_req_ready = 0;
    expect_req(OP_LW, 32'h700, 32'h0, 5'd22);
    disp(OP_LW, 5'd22, 0, 0, 32'h700, 32'h0, 32'h0);
    tick();
    expect_req(OP_SW, 32'h900, 32'h23, 5'd23);
    disp(OP_SW, 5'd23, 0, 0, 32'h900, 32'h23, 32'h0);
    commit_valid = 1; commit_tag = 5'd23;
    tick();
    commit_valid = 0;
    disp(OP_LW, 5'd24, 0, 0, 32'hA00, 32'h0, 32'h0);
    disp(OP_SW, 5'd25, 0, 0, 32'hB00, 32'h0, 32'h0);
    chk("rb_count_before", 32'(count), 3);
    rollback = 1; commit_valid = 1; commit_tag = 5'd25;
    disp(OP_LW, 5'd27, 0, 0, 32'hE00, 32'h0, 32'h0);
    rollback = 0; commit_valid = 0;
    chk("rb_count_after", 32'(count), 1);
    chk("rb_held_valid", 32'(mem_req_valid), 1);
    chk("rb_held_addr", mem_req_addr, 32'h700);
    chk("rb_held_tag", 32'(mem_req_tag), 22);
    expect_req(OP_LW, 32'hC00, 32'h0, 5'd26);
    disp(OP_LW, 5'd26, 0, 0, 32'hC00, 32'h0, 32'h0);
    chk("rb_count_refill", 32'(count), 2);
    mem_req_ready = 1;
    wait_idle(20);
    chk("rb_sb_empty", 32'(exp_q.size()), 0);

    // Global enable low freezes everything.
    rdy_in = 0;
    disp(OP_LW, 5'd28, 0, 0, 32'h0, 32'h0, 32'h0);
    tick();
    chk("frz_count", 32'(count), 0);
    chk("frz_valid", 32'(mem_req_valid), 0);
    rdy_in = 1;

    // Reset in the middle of a pending request discards it.
    mem_req_ready = 0;
    disp(OP_LW, 5'd29, 0, 0, 32'hD00, 32'h0, 32'h0);
    tick();
    chk("mid_rst_pending", 32'(mem_req_valid), 1);
    rst_in = 1;
    tick();
    rst_in = 0;
    chk("mid_rst_valid", 32'(mem_req_valid), 0);
    chk("mid_rst_addr", mem_req_addr, 0);
    chk("mid_rst_count", 32'(count), 0);
    mem_req_ready = 1;
    tick();
    chk("final_sb_empty", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_queue.md
LOAD_STORE_QUEUE -- requirements
Module: load_store_queue

Interface
REQ-001 SHALL have parameter DEPTH, 16, entry count, power of two, 4..64.
REQ-002 SHALL have parameter TAG_W, 5, ROB tag width; tag 0 = "no dependency / none".
REQ-003 SHALL have parameter FULL_MARGIN, 2, slots reserved before full_warn asserts.
REQ-004 SHALL have parameter IO_ADDR, 32'h00030000, memory-mapped I/O address (`RAM_IO_PORT).
REQ-005 SHALL have ports clk_in in 1 clock; rst_in in 1 reset; rdy_in in 1 global enable; one clock; reset is synchronous and active-high.
REQ-006 SHALL have ports disp_valid in 1; disp_op in 6; disp_q1, disp_q2 in TAG_W; disp_v1, disp_v2 in 32; disp_imm in 32; disp_tag in TAG_W -- dispatch of one load/store.
REQ-007 SHALL have ports cdb0_valid in 1, cdb0_tag in TAG_W, cdb0_data in 32; cdb1_valid in 1, cdb1_tag in TAG_W, cdb1_data in 32 -- result broadcasts (ALU, LSU).
REQ-008 SHALL have ports commit_valid in 1, commit_tag in TAG_W; rob_io_head_tag in TAG_W; rollback in 1.
REQ-009 SHALL have ports mem_req_valid out 1; mem_req_ready in 1; mem_req_op out 6; mem_req_addr out 32; mem_req_wdata out 32; mem_req_tag out TAG_W.
REQ-010 SHALL have ports io_tag out TAG_W; count out clog2(DEPTH)+1; full_warn out 1; empty out 1.

Function
REQ-011 SHALL be a circular FIFO; head/tail are clog2(DEPTH) bits, wrap DEPTH-1 -> 0 naturally; load = op <= `LHU, store = op >= `SB.
REQ-012 SHALL insert at tail when disp_valid and count < DEPTH; disp_valid at count == DEPTH SHALL be dropped without state change.
REQ-013 SHALL bypass on insert: disp_qN matching a valid CDB tag (cdb0 first) stores data, qN = 0; qN == 0 never matches.
REQ-014 SHALL wake resident entries: qN == valid cdbX_tag, qN != 0 -> vN <= data, qN <= 0, both CDBs same cycle.
REQ-015 SHALL compute address = v1 + imm modulo 2^32.
REQ-016 SHALL treat head eligible when busy, q1 == q2 == 0, and (load with addr != IO_ADDR or rob_io_head_tag == entry tag) or (store with committed set).
REQ-017 SHALL issue when head eligible and (!mem_req_valid or mem_req_ready): next cycle mem_req_valid = 1 with op, addr, wdata = v2, tag; entry freed; head advances.
REQ-018 SHALL hold mem_req_* stable while mem_req_valid && !mem_req_ready; mem_req_valid drops after acceptance unless a new issue occurs that cycle.
REQ-019 SHALL set committed on entry with busy, tag == commit_tag, !committed when commit_valid.
REQ-020 SHALL drive io_tag combinationally = head tag when head busy, q1 == 0, addr == IO_ADDR, else 0.
REQ-021 SHALL update count by +insert -issue same cycle; empty = (count == 0); full_warn = (count >= DEPTH - FULL_MARGIN).
REQ-022 SHALL on rollback: free all uncommitted entries and loads, keep committed stores (contiguous from head), tail <= head + kept, count <= kept; same-cycle dispatch, commit, wakeup and new issue ignored; pending mem_req held until accepted.
REQ-023 SHALL freeze all state and outputs while rdy_in == 0 (rst_in excepted).

Reset
REQ-024 SHALL on rst_in clear all entries, head = tail = 0, count = 0, mem_req_valid = 0, mem_req_* = 0, empty = 1, full_warn = 0; mid-operation reset discards pending request.

Verification
REQ-025 Load q1=0 v1=0x100 imm=4, ready=1 -> next cycle mem_req_valid, addr 0x104; following cycle valid=0, count 0.
REQ-026 Store q1=3 dispatched, cdb1 tag 3 data 0x2000 next cycle, commit tag -> request addr 0x2000+imm, wdata v2, only after commit.
REQ-027 Load addr IO_ADDR tag 7, rob_io_head_tag 0 -> io_tag 7, no issue; rob_io_head_tag 7 -> issue.
REQ-028 DEPTH=4: 5 dispatches no issue -> count 4, 5th dropped, full_warn at count 2; wrap after drain/refill correct.
REQ-029 Committed store, uncommitted load, store queued; rollback with mem_req_ready=0 -> count 1, tail = head+1, held request unchanged.
REQ-030 mem_req_ready=0 3 cycles with eligible head -> mem_req_* stable, head unchanged; ready=1 -> next entry issues following cycle.
